// File: rtl/updown_counter_pkg.sv
// Shared constants and encodings for the parametrised up/down counter.
// Optional build macro used by the counter: UPDN_CNT_PRESCALE_EN.
package updown_counter_pkg;

    localparam int UPDN_DEFAULT_WIDTH = 8;

    typedef enum logic {
        DOWN = 1'b0,
        UP   = 1'b1
    } step_dir_e;

    typedef enum logic {
        WRAP = 1'b0,
        SAT  = 1'b1
    } cnt_mode_e;

endpackage : updown_counter_pkg

// File: rtl/cnt_prescaler.sv
// Enable divider: emits a one-cycle step_tick_o on every PRESCALE-th en_i cycle.
// The divider restarts from zero on clear_i or load_i and holds while en_i is low.
module cnt_prescaler #(
    parameter int PRESCALE = 4
) (
    input  logic clk_i,
    input  logic clear_i,
    input  logic load_i,
    input  logic en_i,
    output logic step_tick_o
);

    localparam int DIV_W = $clog2(PRESCALE);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PRESCALE - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;

    // Divider next state and tick generation.
    always_comb begin
        div_d       = div_q;
        step_tick_o = 1'b0;
        if (clear_i || load_i) begin
            div_d = '0;
        end else if (en_i) begin
            if (div_q == DIV_LAST) begin
                div_d       = '0;
                step_tick_o = 1'b1;
            end else begin
                div_d = div_q + DIV_ONE;
            end
        end else begin
            div_d = div_q;
        end
    end

    // Divider state register.
    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule : cnt_prescaler

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with programmable limit, wrap/saturate, load, tc and sticky ovf.
// Define UPDN_CNT_PRESCALE_EN to divide the count enable by PRESCALE.
module updown_counter_param
    import updown_counter_pkg::*;
#(
    parameter int WIDTH     = UPDN_DEFAULT_WIDTH,
    parameter int RESET_VAL = 0,
    parameter int PRESCALE  = 4
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             en,
    input  logic             dir_up,
    input  logic             sat_mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] CNT_RESET = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] CNT_ZERO  = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONE   = WIDTH'(1);

    if (WIDTH < 2 || PRESCALE < 2 || RESET_VAL < 0 ||
        (WIDTH < 31 && RESET_VAL > ((2 ** WIDTH) - 1))) begin : g_bad_params
        $error("updown_counter_param: illegal WIDTH/RESET_VAL/PRESCALE");
    end

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             tc_q;
    logic             tc_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             step_s;
    step_dir_e        dir_s;
    cnt_mode_e        mode_s;

    assign dir_s  = step_dir_e'(dir_up);
    assign mode_s = cnt_mode_e'(sat_mode);

`ifdef UPDN_CNT_PRESCALE_EN
    cnt_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk_i       (clk),
        .clear_i     (clear),
        .load_i      (load),
        .en_i        (en),
        .step_tick_o (step_s)
    );
`else
    assign step_s = en;
`endif

    // Count/tc next state; load beats step, boundary steps raise tc.
    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        if (load) begin
            count_d = (load_val > limit) ? limit : load_val;
        end else if (step_s) begin
            case (dir_s)
                UP: begin
                    // >= covers a limit lowered below the current count
                    if (count_q < limit) begin
                        count_d = count_q + CNT_ONE;
                    end else begin
                        count_d = (mode_s == SAT) ? limit : CNT_ZERO;
                        tc_d    = 1'b1;
                    end
                end
                DOWN: begin
                    if (count_q != CNT_ZERO) begin
                        count_d = count_q - CNT_ONE;
                    end else begin
                        count_d = (mode_s == SAT) ? CNT_ZERO : limit;
                        tc_d    = 1'b1;
                    end
                end
                default: begin
                    count_d = count_q;
                    tc_d    = 1'b0;
                end
            endcase
        end else begin
            count_d = count_q;
        end
    end

    // Sticky overflow: a new tc event wins over a simultaneous clr_ovf.
    always_comb begin
        ovf_d = ovf_q;
        if (tc_d) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Output registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (clear) begin
            count_q <= CNT_RESET;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign ovf   = ovf_q;

endmodule : updown_counter_param

// File: doc/updown_counter_param.md
Name: updown_counter_param

Overview:
- Parametrised up/down counter; successor to the fixed 3-bit up/down counter.
- Generalises width and adds:
  - run-time programmable upper limit (modulus)
  - wrap or saturate mode
  - count enable
  - synchronous parallel load
  - terminal-count pulse
  - sticky overflow flag
- Used as a general event/position counter and timebase in datapath and control blocks; one clock domain.

Parameters:
- WIDTH, 8, counter width in bits (>= 2).
- RESET_VAL, 0, value of count after clear; must be <= 2^WIDTH-1.
- PRESCALE, 4, enable divider ratio; used only when UPDN_CNT_PRESCALE_EN is defined; must be >= 2.

Ports:
- clk  input  1  rising-edge clock
- clear  input  1  synchronous reset, active-high
- en  input  1  count enable; a step occurs only when en=1
- dir_up  input  1  1 = count up, 0 = count down
- sat_mode  input  1  1 = saturate at bounds, 0 = wrap
- load  input  1  synchronous parallel load strobe
- load_val  input  WIDTH  value to load
- limit  input  WIDTH  upper bound; count range is 0..limit
- clr_ovf  input  1  clears the sticky ovf flag
- count  output  WIDTH  registered counter value
- tc  output  1  registered one-cycle terminal-count pulse
- ovf  output  1  sticky boundary-event flag

Behaviour:
- One clock. Reset is synchronous and active-high, on port clear. All outputs are registered.
- Reset values: count=RESET_VAL, tc=0, ovf=0.
- Priority each rising edge: clear > load > step (en) > hold.
- Load:
  - count <= min(load_val, limit); tc <= 0; ovf unchanged.
  - en is ignored in a load cycle.
- Step, up (en=1, dir_up=1):
  - count < limit: count+1, tc=0.
  - count >= limit, wrap mode: count <= 0, tc <= 1.
  - count >= limit, saturate mode: count <= limit, tc <= 1.
- Step, down (en=1, dir_up=0):
  - count > 0: count-1, tc=0.
  - count == 0, wrap mode: count <= limit, tc <= 1.
  - count == 0, saturate mode: count stays 0, tc <= 1.
  - If count > limit at that time (limit lowered below count), a down step is the normal decrement.
- tc:
  - High for exactly the cycle after the boundary step, together with the new count.
  - Consecutive boundary steps in saturate mode give tc high on every such cycle.
- ovf:
  - Set on any cycle where tc is set.
  - Cleared by clr_ovf=1 when no tc event occurs in the same cycle; tc set wins a simultaneous clr_ovf.
  - Cleared by clear.
- Hold (en=0, no load): count held, tc <= 0.
- limit=0: count remains 0 and every step produces tc=1.
- dir_up, sat_mode and limit may change on any cycle and take effect on the same edge. There is no pipeline.
- clear mid-count overrides everything and returns all outputs to reset values on the next edge.
- Arithmetic is unsigned, WIDTH bits; no intermediate result exceeds WIDTH bits. With limit=2^WIDTH-1, up-wrap equals natural rollover.

Optional Feature:
- UPDN_CNT_PRESCALE_EN defined:
  - An internal divider counts en-qualified cycles; a step occurs only on every PRESCALE-th such cycle.
  - The divider is reset to 0 by clear and by load.
  - The divider holds when en=0.
- Not defined: every en=1 cycle is a step; PRESCALE is unused and no divider logic is built.

Decomposition:
- Package updown_counter_pkg holds:
  - default WIDTH constant
  - step-direction encoding (UP=1, DOWN=0)
  - mode encoding (WRAP=0, SAT=1)
- Sub-module cnt_prescaler: parametrised divider producing a one-cycle step_tick from en, reset by clear or load. It is instantiated only under UPDN_CNT_PRESCALE_EN.

Test Plan:
- Reset and up-wrap: WIDTH=3, clear 5 cycles, then limit=5, en=1, dir_up=1, wrap → count 0,1,2,3,4,5,0; tc=1 only with the 0; ovf=1 thereafter.
- Down saturate: sat_mode=1, load_val=2, load, then dir_up=0 for 5 cycles → count 2,1,0,0,0; tc=1 on each held-0 cycle.
- Load clamp and priority: limit=4, load_val=7 with load=1 and en=1 together → count=4; load and clear together → count=RESET_VAL.
- Limit lowered below count: count=6, limit set to 3, up step → count=0 and tc=1; alternatively a down step → count=5 and tc=0.
- ovf handling: generate a tc, then clr_ovf=1 in a quiet cycle → ovf=0; clr_ovf=1 in the same cycle as a wrap → ovf stays 1.
- Prescale (UPDN_CNT_PRESCALE_EN, PRESCALE=4): en=1 for 12 cycles from count=0 → count increments only every 4th cycle, reaching 3; an en=0 gap does not lose divider progress.
